pll_lock_sequencer: RTL and testbench

- Reset sequencer that sits directly downstream of the core PLL. Runs on the free-running reference clock (74.25 MHz), which is present while the PLL is still unlocked.
- Drives the PLL's reset input and consumes its asynchronous locked output.
- Holds the system reset asserted until lock has stayed stable for a settle period.
- Re-initialises the PLL on a lock timeout or a lock loss. Per-domain reset synchronisers for the generated clocks live elsewhere and consume sys_rst.

---
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Reset sequencer downstream of the core PLL: pulses the PLL reset, waits for a
// stable synchronised lock, then releases the system reset and supervises lock.
module pll_lock_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 1000000,
   parameter int unsigned SETTLE_CYCLES  = 1024,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned CNT_W          = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       lock_lost_clr,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       lock_lost,
   output logic [7:0] retry_count,
   output logic [1:0] state_o
);

   localparam int unsigned RETRY_W = 8;
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   typedef enum logic [1:0] {
      S_RESET_PLL = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_SETTLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t                   state;
   state_t                   state_d;
   logic [CNT_W-1:0]         cnt;
   logic [CNT_W-1:0]         cnt_d;
   logic [SYNC_STAGES-1:0]   sync;
   logic                     locked_s;
   logic                     retry_inc;
   logic                     lost_set;
   logic                     pll_rst_d;
   logic                     sys_rst_d;
   logic                     ready_d;
   logic                     lock_lost_d;
   logic [RETRY_W-1:0]       retry_d;

   // Locked synchroniser: pll_locked is asynchronous to clk
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign locked_s = sync[SYNC_STAGES-1];

   // State register and shared phase counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RESET_PLL;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state logic; the counter is reused for pulse length, timeout and settle
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      retry_inc = 1'b0;
      lost_set  = 1'b0;
      case (state)
         S_RESET_PLL: begin
            if (cnt == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else if (cnt == TMO_LAST) begin
               state_d   = S_RESET_PLL;
               cnt_d     = '0;
               retry_inc = 1'b1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         S_SETTLE: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt == SETTLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            // No filtering here: any low sample restarts the full sequence
            if (!locked_s) begin
               state_d  = S_RESET_PLL;
               lost_set = 1'b1;
            end
         end
         default: begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the next state so outputs move with the transition
   always_comb begin
      pll_rst_d   = (state_d == S_RESET_PLL);
      sys_rst_d   = (state_d != S_RUN);
      ready_d     = (state_d == S_RUN);
      lock_lost_d = lost_set | (lock_lost & ~lock_lost_clr);
      retry_d     = retry_count;
      if (retry_inc && (retry_count != RETRY_MAX)) begin
         retry_d = retry_count + RETRY_W'(1);
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         lock_lost   <= 1'b0;
         retry_count <= '0;
      end else begin
         pll_rst     <= pll_rst_d;
         sys_rst     <= sys_rst_d;
         ready       <= ready_d;
         lock_lost   <= lock_lost_d;
         retry_count <= retry_d;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/time reference model predicts
// every cycle's outputs; directed scenarios add cycle-exact landmark checks.
module tb_pll_lock_sequencer;

   localparam int unsigned PLL_RST = 4;
   localparam int unsigned LOCK_TO = 20;
   localparam int unsigned SETTLE  = 8;
   localparam int unsigned SYNC    = 2;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       lock_lost_clr;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       lock_lost;
   logic [7:0] retry_count;
   logic [1:0] state_o;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES(PLL_RST),
      .LOCK_TIMEOUT  (LOCK_TO),
      .SETTLE_CYCLES (SETTLE),
      .SYNC_STAGES   (SYNC),
      .CNT_W         (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked   (pll_locked),
      .lock_lost_clr(lock_lost_clr),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .lock_lost    (lock_lost),
      .retry_count  (retry_count),
      .state_o      (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pll_rst;
      logic       sys_rst;
      logic       ready;
      logic       lock_lost;
      logic [7:0] retry;
      logic [1:0] state;
   } exp_t;

   typedef enum logic [1:0] {PH_PLLRST = 2'd0, PH_WAIT = 2'd1, PH_SETTLE = 2'd2, PH_RUN = 2'd3} ph_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: phase plus cycles elapsed in it; lock seen SYNC edges late
   ph_t  m_phase;
   int   m_t;
   int   m_retries;
   bit   m_lost;
   bit   m_hist[$];

   function automatic void model_reset();
      m_phase   = PH_PLLRST;
      m_t       = 0;
      m_retries = 0;
      m_lost    = 1'b0;
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
   endfunction

   function automatic void model_edge(bit r, bit l, bit c);
      bit ls;
      bit set_lost;
      set_lost = 1'b0;
      if (r) begin
         model_reset();
         return;
      end
      ls = m_hist.pop_front();
      m_hist.push_back(l);
      case (m_phase)
         PH_PLLRST: begin
            m_t++;
            if (m_t >= PLL_RST) begin m_phase = PH_WAIT; m_t = 0; end
         end
         PH_WAIT: begin
            if (ls) begin
               m_phase = PH_SETTLE; m_t = 0;
            end else begin
               m_t++;
               if (m_t >= LOCK_TO) begin
                  m_retries = (m_retries < 255) ? m_retries + 1 : 255;
                  m_phase   = PH_PLLRST;
                  m_t       = 0;
               end
            end
         end
         PH_SETTLE: begin
            if (!ls) begin
               m_phase = PH_WAIT; m_t = 0;
            end else begin
               m_t++;
               if (m_t >= SETTLE) begin m_phase = PH_RUN; m_t = 0; end
            end
         end
         PH_RUN: begin
            if (!ls) begin m_phase = PH_PLLRST; m_t = 0; set_lost = 1'b1; end
         end
         default: ;
      endcase
      if (set_lost) m_lost = 1'b1;
      else if (c)   m_lost = 1'b0;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.pll_rst   = (m_phase == PH_PLLRST);
      e.sys_rst   = (m_phase != PH_RUN);
      e.ready     = (m_phase == PH_RUN);
      e.lock_lost = m_lost;
      e.retry     = 8'(m_retries);
      e.state     = m_phase;
      return e;
   endfunction

   // Drive one cycle of inputs and queue the outputs expected after the next edge
   task automatic step(input bit r, input bit l, input bit c);
      @(negedge clk);
      rst           = r;
      pll_locked    = l;
      lock_lost_clr = c;
      model_edge(r, l, c);
      exp_q.push_back(model_out());
   endtask

   task automatic settle_after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int n, input bit l);
      for (int i = 0; i < n; i++) step(1'b1, l, 1'b0);
   endtask

   task automatic dchk(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Monitor: compare every post-edge output against the scoreboard
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, sys_rst, ready, lock_lost, retry_count, state_o};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle_outputs t=%0t: got pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry=%0d state=%0d, expected pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry=%0d state=%0d",
                        $time, a.pll_rst, a.sys_rst, a.ready, a.lock_lost, a.retry, a.state,
                        e.pll_rst, e.sys_rst, e.ready, e.lock_lost, e.retry, e.state);
            end
         end
      end
   end

   initial begin
      int  len;
      bit  v;
      bit  r;
      bit  c;
      rst           = 1'b1;
      pll_locked    = 1'b0;
      lock_lost_clr = 1'b0;
      model_reset();

      // Lock already present: release latency and reset values
      do_reset(3, 1'b1);
      settle_after_edge();
      dchk("rst_state", state_o, 0);
      dchk("rst_pll_rst", pll_rst, 1);
      dchk("rst_sys_rst", sys_rst, 1);
      dchk("rst_ready", ready, 0);
      dchk("rst_lock_lost", lock_lost, 0);
      dchk("rst_retry", retry_count, 0);
      for (int i = 1; i <= 14; i++) begin
         step(1'b0, 1'b1, 1'b0);
         settle_after_edge();
         if (i == 3)  dchk("s1_pll_rst_c3", pll_rst, 1);
         if (i == 4)  begin dchk("s1_pll_rst_c4", pll_rst, 0); dchk("s1_state_c4", state_o, 1); end
         if (i == 5)  dchk("s1_state_c5", state_o, 2);
         if (i == 12) dchk("s1_ready_c12", ready, 0);
         if (i == 13) begin dchk("s1_ready_c13", ready, 1); dchk("s1_sys_rst_c13", sys_rst, 0); end
      end

      // No lock: retry every PLL_RST + LOCK_TO cycles
      do_reset(2, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         step(1'b0, 1'b0, 1'b0);
         settle_after_edge();
         if (i == 23)  dchk("s2_retry_c23", retry_count, 0);
         if (i == 24)  dchk("s2_retry_c24", retry_count, 1);
         if (i == 95)  dchk("s2_retry_c95", retry_count, 3);
         if (i == 100) begin dchk("s2_retry_c100", retry_count, 4); dchk("s2_sys_rst", sys_rst, 1); end
      end

      // Glitch during SETTLE restarts the settle window
      do_reset(2, 1'b1);
      for (int i = 1; i <= 24; i++) begin
         step(1'b0, (i == 10) ? 1'b0 : 1'b1, 1'b0);
         settle_after_edge();
         if (i == 12) dchk("s3_state_wait", state_o, 1);
         if (i == 13) dchk("s3_state_settle", state_o, 2);
         if (i == 20) dchk("s3_ready_c20", ready, 0);
         if (i == 21) dchk("s3_ready_c21", ready, 1);
      end

      // Lock loss in RUN, recovery, clear, and set-beats-clear
      do_reset(2, 1'b1);
      for (int i = 1; i <= 60; i++) begin
         step(1'b0, (i == 21 || i == 50) ? 1'b0 : 1'b1, (i == 42 || i == 52));
         settle_after_edge();
         if (i == 22) begin dchk("s4_ready_pre", ready, 1); dchk("s4_lost_pre", lock_lost, 0); end
         if (i == 23) begin
            dchk("s4_sys_rst", sys_rst, 1);
            dchk("s4_ready", ready, 0);
            dchk("s4_pll_rst", pll_rst, 1);
            dchk("s4_lost", lock_lost, 1);
            dchk("s4_state", state_o, 0);
         end
         if (i == 35) dchk("s4_ready_c35", ready, 0);
         if (i == 36) dchk("s4_ready_c36", ready, 1);
         if (i == 41) dchk("s4_lost_sticky", lock_lost, 1);
         if (i == 42) dchk("s4_lost_cleared", lock_lost, 0);
         if (i == 52) dchk("s4_set_wins", lock_lost, 1);
         if (i == 53) dchk("s4_retry_unchanged", retry_count, 0);
      end

      // Retry counter saturation
      do_reset(2, 1'b0);
      for (int i = 1; i <= 6150; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (i == 6119 || i == 6120 || i == 6150) begin
            settle_after_edge();
            if (i == 6119) dchk("s5_retry_254", retry_count, 254);
            if (i == 6120) dchk("s5_retry_255", retry_count, 255);
            if (i == 6150) dchk("s5_retry_sat", retry_count, 255);
         end
      end

      // rst while in RUN with lock_lost set and retries recorded
      do_reset(2, 1'b0);
      repeat (72) step(1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 60 && m_phase != PH_RUN; g++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      for (int g = 0; g < 60 && m_phase != PH_RUN; g++) step(1'b0, 1'b1, 1'b0);
      settle_after_edge();
      dchk("s6_ready", ready, 1);
      dchk("s6_lost", lock_lost, 1);
      dchk("s6_retry", retry_count, 3);
      step(1'b1, 1'b1, 1'b0);
      settle_after_edge();
      dchk("s6_state", state_o, 0);
      dchk("s6_pll_rst", pll_rst, 1);
      dchk("s6_sys_rst", sys_rst, 1);
      dchk("s6_ready_rst", ready, 0);
      dchk("s6_lost_rst", lock_lost, 0);
      dchk("s6_retry_rst", retry_count, 0);
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b1, 1'b0);
         settle_after_edge();
         if (i == 3) dchk("s6_pulse_c3", pll_rst, 1);
         if (i == 4) dchk("s6_pulse_c4", pll_rst, 0);
      end

      // Randomised lock segments with sporadic clears and resets
      for (int seg = 0; seg < 150; seg++) begin
         len = $urandom_range(1, 35);
         v   = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < len; k++) begin
            r = ($urandom_range(0, 599) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(r, v, c);
         end
      end

      settle_after_edge();
      dchk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
